// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong frame buffer, natural order in, bit-reversed out.
// Define BITREV_BYPASS_EN to add a per-frame natural-order bypass input.
module bitrev_reorder_buf #(
  parameter int LOG_N = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef BITREV_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last
);

  localparam int N = 1 << LOG_N;

  typedef logic [LOG_N-1:0] idx_t;

  localparam idx_t IDX_LAST = '1;

  logic [W-1:0] mem [2][N];
  logic [1:0]   full;
  logic         wr_sel;
  logic         rd_sel;
  idx_t         wr_idx;
  idx_t         rd_idx;
  idx_t         rd_addr;
  logic         wr_fire;
  logic         rd_fire;
  logic         wr_done;
  logic         rd_done;
  logic         rd_nat;

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    r = '0;
    for (int k = 0; k < LOG_N; k++) r[k] = i[LOG_N-1-k];
    return r;
  endfunction

  assign s_ready = rst_n & ~full[wr_sel];
  assign m_valid = full[rd_sel];
  assign wr_fire = s_valid & s_ready;
  assign rd_fire = m_valid & m_ready;
  assign wr_done = wr_fire & (wr_idx == IDX_LAST);
  assign rd_done = rd_fire & (rd_idx == IDX_LAST);

`ifdef BITREV_BYPASS_EN
  logic [1:0] mode;

  // latch each bank's order mode on the first coefficient of its frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= '0;
    end else if (wr_fire && wr_idx == '0) begin
      mode[wr_sel] <= bypass;
    end
  end

  assign rd_nat = mode[rd_sel];
`else
  assign rd_nat = 1'b0;
`endif

  assign rd_addr = rd_nat ? rd_idx : bitrev(rd_idx);
  assign m_data  = m_valid ? mem[rd_sel][rd_addr] : '0;
  assign m_last  = m_valid & (rd_idx == IDX_LAST);

  // coefficient storage, written in arrival order, never reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_sel][wr_idx] <= s_data;
    end
  end

  // write pointer: fill a bank, then hand it to the reader
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sel <= 1'b0;
      wr_idx <= '0;
    end else if (wr_fire) begin
      wr_idx <= wr_idx + idx_t'(1);
      if (wr_done) wr_sel <= ~wr_sel;
    end
  end

  // read pointer: drain a bank, then hand it back to the writer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
      rd_idx <= '0;
    end else if (rd_fire) begin
      rd_idx <= rd_idx + idx_t'(1);
      if (rd_done) rd_sel <= ~rd_sel;
    end
  end

  // bank ownership flags; fill and drain always hit different banks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_done) full[wr_sel] <= 1'b1;
      if (rd_done) full[rd_sel] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// tb_bitrev_reorder_buf: randomized and directed checks of the reorder buffer
// against a queue-based frame model.
module tb_bitrev_reorder_buf;

  localparam int LOG_N = 3;
  localparam int N     = 1 << LOG_N;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bypass;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] inq[$];
  logic [W-1:0] outq[$];
  logic [W-1:0] got[$];
  bit           fbyp;

  logic         e_valid;
  logic         e_last;
  logic         e_sready;
  logic [W-1:0] e_data;

  always #5 clk = ~clk;

  bitrev_reorder_buf #(.LOG_N(LOG_N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef BITREV_BYPASS_EN
    .bypass  (bypass),
`endif
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < LOG_N; b++)
      if ((k >> b) & 1) r |= 1 << (LOG_N - 1 - b);
    return r;
  endfunction

  // expected outputs: a frame per N buffered values, at most two frames held
  task automatic expect_now();
    int frames;
    frames   = (outq.size() + N - 1) / N;
    e_valid  = outq.size() > 0;
    e_data   = e_valid ? outq[0] : '0;
    e_last   = e_valid && (outq.size() % N == 1);
    e_sready = rst_n && (frames < 2);
  endtask

  task automatic tick();
    bit wf;
    bit rf;
    expect_now();
    wf = s_valid && e_sready;
    rf = m_ready && e_valid;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      inq.delete();
      outq.delete();
    end else begin
      if (rf) void'(outq.pop_front());
      if (wf) begin
        if (inq.size() == 0) fbyp = bypass;
        inq.push_back(s_data);
        if (inq.size() == N) begin
          for (int k = 0; k < N; k++)
            outq.push_back(fbyp ? inq[k] : inq[brev(k)]);
          inq.delete();
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    bypass  = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h55;
    m_ready = 1'b1;
    bypass  = 1'b0;
    tick();
    vectors++;
    if ({m_valid, m_last, s_ready, m_data} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_hold got v%b l%b r%b d%h want 0 0 0 00",
               m_valid, m_last, s_ready, m_data);
    end
    rst_n   = 1'b1;
    s_valid = 1'b0;
    #1;
    vectors++;
    if ({m_valid, s_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_release got v%b r%b want v0 r1", m_valid, s_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] want [N] = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
    reset_dut();
    got.delete();
    for (int c = 0; c < 18; c++) begin
      s_valid = c < N;
      s_data  = W'(c);
      m_ready = 1'b1;
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL basic c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
    end
    vectors++;
    if (got.size() != N) begin
      miscompares++;
      $display("FAIL basic_count got %0d want %0d", got.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        vectors++;
        if (got[k] !== want[k]) begin
          miscompares++;
          $display("FAIL basic_seq[%0d] got %h want %h", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int c = 0; c < 36; c++) begin
      s_valid = c < 24;
      s_data  = W'(8'h10 + c);
      m_ready = 1'b1;
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL b2b c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      if (c >= 8 && c < 32 && !m_valid) begin
        miscompares++;
        $display("FAIL b2b_bubble c=%0d got v%b want v1", c, m_valid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int c = 0; c < 50; c++) begin
      s_valid = c < 26;
      s_data  = W'($urandom);
      m_ready = c >= 17;
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL backpressure c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      if (c == 16 && s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL both_full got r%b want r0", s_ready);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int stalls;
    stalls = 0;
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      s_valid = c < N;
      s_data  = W'(c);
      if (m_valid && m_data == 8'h06 && stalls < 3) begin
        m_ready = 1'b0;
        stalls++;
      end else begin
        m_ready = 1'b1;
      end
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL stall c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] want [N] = '{8'hA0, 8'hA4, 8'hA2, 8'hA6, 8'hA1, 8'hA5, 8'hA3, 8'hA7};
    reset_dut();
    got.delete();
    for (int c = 0; c < 24; c++) begin
      rst_n   = c != 5;
      s_valid = c < 5 || (c >= 6 && c < 14);
      s_data  = c < 5 ? W'($urandom) : W'(8'hA0 + c - 6);
      m_ready = 1'b1;
      #1;
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL reset_mid c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
    end
    rst_n = 1'b1;
    vectors++;
    if (got.size() != N) begin
      miscompares++;
      $display("FAIL reset_mid_count got %0d want %0d", got.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        vectors++;
        if (got[k] !== want[k]) begin
          miscompares++;
          $display("FAIL reset_mid_seq[%0d] got %h want %h", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 430; c++) begin
      s_valid = c < 400 && ($urandom % 4 != 0);
      s_data  = W'($urandom);
      m_ready = c >= 400 || ($urandom % 3 != 0);
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL random c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      tick();
    end
  endtask

`ifdef BITREV_BYPASS_EN
  task automatic test_bypass();
    logic [W-1:0] want [2*N] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                 8'd8, 8'd12, 8'd10, 8'd14, 8'd9, 8'd13, 8'd11, 8'd15};
    reset_dut();
    got.delete();
    for (int c = 0; c < 30; c++) begin
      s_valid = c < 2 * N;
      s_data  = W'(c);
      bypass  = c == 0;
      m_ready = 1'b1;
      expect_now();
      vectors++;
      if ({m_valid, m_last, s_ready, m_data} !== {e_valid, e_last, e_sready, e_data}) begin
        miscompares++;
        $display("FAIL bypass c=%0d got v%b l%b r%b d%h want v%b l%b r%b d%h", c,
                 m_valid, m_last, s_ready, m_data, e_valid, e_last, e_sready, e_data);
      end
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
    end
    bypass = 1'b0;
    vectors++;
    if (got.size() != 2 * N) begin
      miscompares++;
      $display("FAIL bypass_count got %0d want %0d", got.size(), 2 * N);
    end else begin
      for (int k = 0; k < 2 * N; k++) begin
        vectors++;
        if (got[k] !== want[k]) begin
          miscompares++;
          $display("FAIL bypass_seq[%0d] got %h want %h", k, got[k], want[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    bypass  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    fbyp    = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef BITREV_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
